// File: rtl/lsu_mem_master.sv
// Load/store initiator for a word-wide data memory port. Handles byte/half/word
// accesses with read-modify-write for sub-word stores and sign/zero-extended loads.
module lsu_mem_master #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned MEM_WORDS  = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req,
    input  logic                  we_req,
    input  logic [1:0]            size,
    input  logic                  unsigned_ld,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  ready,
    output logic                  done,
    output logic                  err,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wd,
    output logic                  mem_we,
    output logic                  mem_re,
    input  logic [DATA_WIDTH-1:0] mem_rd
);

    typedef enum logic [1:0] {StIdle, StRd, StWr, StResp} state_e;

    localparam logic [1:0] SzByte = 2'b00;
    localparam logic [1:0] SzHalf = 2'b01;
    localparam logic [1:0] SzWord = 2'b10;

    state_e                state_q, state_d;
    logic                  we_q, we_d;
    logic [1:0]            size_q, size_d;
    logic                  uns_q, uns_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] rdbuf_q, rdbuf_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic                  req_err;
    logic [7:0]            ld_byte;
    logic [15:0]           ld_half;
    logic [DATA_WIDTH-1:0] ld_ext;
    logic [DATA_WIDTH-1:0] merged;

    always_comb begin
        req_err = 1'b0;
        unique case (size)
            SzByte:  req_err = 1'b0;
            SzHalf:  req_err = addr[0];
            SzWord:  req_err = (addr[1:0] != 2'b00);
            default: req_err = 1'b1;
        endcase
        if ((addr >> 2) >= ADDR_WIDTH'(MEM_WORDS)) begin
            req_err = 1'b1;
        end
    end

    // Lane extraction works straight off mem_rd so rdata can be registered at the RD edge.
    always_comb begin
        ld_byte = mem_rd[{addr_q[1:0], 3'b000} +: 8];
        ld_half = mem_rd[{addr_q[1], 4'b0000} +: 16];
        unique case (size_q)
            SzByte:  ld_ext = {{(DATA_WIDTH-8){~uns_q & ld_byte[7]}}, ld_byte};
            SzHalf:  ld_ext = {{(DATA_WIDTH-16){~uns_q & ld_half[15]}}, ld_half};
            default: ld_ext = mem_rd;
        endcase
    end

    always_comb begin
        merged = rdbuf_q;
        unique case (size_q)
            SzByte:  merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            SzHalf:  merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            default: merged = wdata_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        rdbuf_d = rdbuf_q;
        rdata_d = rdata_q;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    we_d    = we_req;
                    size_d  = size;
                    uns_d   = unsigned_ld;
                    addr_d  = addr;
                    wdata_d = wdata;
                    err_d   = req_err;
                    if (req_err) begin
                        state_d = StResp;
                    end else if (we_req && size == SzWord) begin
                        state_d = StWr;
                    end else begin
                        state_d = StRd;
                    end
                end
            end
            StRd: begin
                rdbuf_d = mem_rd;
                if (we_q) begin
                    state_d = StWr;
                end else begin
                    rdata_d = ld_ext;
                    state_d = StResp;
                end
            end
            StWr:   state_d = StResp;
            StResp: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rdbuf_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            rdbuf_q <= rdbuf_d;
            rdata_q <= rdata_d;
        end
    end

    // Strobes decode from state alone, so asserting reset kills mem_we at once.
    assign ready    = (state_q == StIdle);
    assign done     = (state_q == StResp);
    assign err      = (state_q == StResp) & err_q;
    assign rdata    = rdata_q;
    assign mem_re   = (state_q == StRd);
    assign mem_we   = (state_q == StWr);
    assign mem_addr = {2'b00, addr_q[ADDR_WIDTH-1:2]};
    assign mem_wd   = (state_q == StWr) ? merged : '0;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Self-checking bench for lsu_mem_master: directed vector table, reset-mid-write
// sequence and randomized traffic against a byte-lane reference model.
module tb_lsu_mem_master;

    localparam int unsigned MemWords = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        we_req = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        unsigned_ld = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        ready, done, err, mem_we, mem_re;
    logic [31:0] rdata, mem_addr, mem_wd, mem_rd;

    logic [31:0] mem [MemWords] = '{default: '0};
    logic        pre_en = 1'b0;
    logic [9:0]  pre_idx = '0;
    logic [31:0] pre_val = '0;

    logic [31:0] ref_mem [MemWords];
    logic [31:0] ref_rdata;

    int checks = 0;
    int errors = 0;

    lsu_mem_master #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(32),
        .MEM_WORDS (MemWords)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .we_req     (we_req),
        .size       (size),
        .unsigned_ld(unsigned_ld),
        .addr       (addr),
        .wdata      (wdata),
        .ready      (ready),
        .done       (done),
        .err        (err),
        .rdata      (rdata),
        .mem_addr   (mem_addr),
        .mem_wd     (mem_wd),
        .mem_we     (mem_we),
        .mem_re     (mem_re),
        .mem_rd     (mem_rd)
    );

    always #5 clk = ~clk;

    assign mem_rd = (mem_addr < MemWords) ? mem[mem_addr[9:0]] : 32'h0;

    always @(posedge clk) begin
        if (mem_we && mem_addr < MemWords) mem[mem_addr[9:0]] <= mem_wd;
        else if (pre_en) mem[pre_idx] <= pre_val;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic preload(input int idx, input logic [31:0] val);
        @(negedge clk);
        pre_en  = 1'b1;
        pre_idx = idx[9:0];
        pre_val = val;
        @(posedge clk);
        #1 pre_en = 1'b0;
        ref_mem[idx] = val;
    endtask

    // Reference: byte-lane arithmetic on a word array, no notion of FSM states.
    task automatic model(input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] d,
                         output logic e, output int lat, output int rc, output int wc);
        int unsigned idx, nbytes, shift;
        logic [31:0] mask, v;
        idx    = a >> 2;
        nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        mask   = (nbytes == 4) ? 32'hFFFF_FFFF : (32'h1 << (8 * nbytes)) - 32'h1;
        shift  = 8 * (a % 4);
        e = (sz == 2'd3) || (a % nbytes != 0) || (idx >= MemWords);
        if (e) begin
            lat = 1; rc = 0; wc = 0;
        end else if (w) begin
            ref_mem[idx] = (ref_mem[idx] & ~(mask << shift)) | ((d & mask) << shift);
            lat = (nbytes == 4) ? 2 : 3;
            rc  = (nbytes == 4) ? 0 : 1;
            wc  = 1;
        end else begin
            v = (ref_mem[idx] >> shift) & mask;
            if (!u && nbytes < 4 && v[8*nbytes-1]) v = v | ~mask;
            ref_rdata = v;
            lat = 2; rc = 1; wc = 0;
        end
    endtask

    task automatic run_req(input logic w, input logic [1:0] sz, input logic u,
                           input logic [31:0] a, input logic [31:0] d,
                           output int lat, output logic e, output logic [31:0] rd,
                           output int wc, output int rc,
                           output logic [31:0] wd, output logic [31:0] wa);
        @(negedge clk);
        chk("ready_before_req", {31'b0, ready}, 32'h1);
        req = 1'b1; we_req = w; size = sz; unsigned_ld = u; addr = a; wdata = d;
        @(posedge clk);
        #1;
        req = 1'b0; addr = $urandom; wdata = $urandom; size = 2'($urandom); we_req = 1'($urandom);
        lat = 0; e = 1'b0; rd = '0; wc = 0; rc = 0; wd = '0; wa = '0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (mem_we) begin wc++; wd = mem_wd; wa = mem_addr; end
            if (mem_re) rc++;
            if (done) begin lat = n; e = err; rd = rdata; break; end
        end
        @(negedge clk);
        chk("done_single_pulse", {31'b0, done}, 32'h0);
        chk("ready_after_resp", {31'b0, ready}, 32'h1);
    endtask

    typedef struct {
        logic        pre_en;
        logic [31:0] pre_val;
        logic        w;
        logic [1:0]  sz;
        logic        u;
        logic [31:0] a;
        logic [31:0] d;
        logic        exp_err;
        int          exp_lat;
        logic [31:0] exp_rdata;
        int          exp_wc;
        int          exp_rc;
        logic [31:0] exp_wd;
    } vec_t;

    vec_t vecs [14];

    initial begin
        int lat, wc, rc, m_lat, m_rc, m_wc;
        logic e, m_e;
        logic [31:0] rd, wd, wa;
        logic [1:0] sz;
        logic [31:0] a;

        for (int i = 0; i < MemWords; i++) ref_mem[i] = '0;
        ref_rdata = '0;

        vecs[0]  = '{0, 0, 1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 0, 2, 32'h0, 1, 0, 32'hDEADBEEF};
        vecs[1]  = '{0, 0, 0, 2'd2, 0, 32'h10, 32'h0, 0, 2, 32'hDEADBEEF, 0, 1, 32'h0};
        vecs[2]  = '{1, 32'h11223344, 1, 2'd0, 0, 32'h12, 32'hAA, 0, 3, 32'hDEADBEEF, 1, 1,
                     32'h11AA3344};
        vecs[3]  = '{0, 0, 0, 2'd0, 0, 32'h12, 32'h0, 0, 2, 32'hFFFFFFAA, 0, 1, 32'h0};
        vecs[4]  = '{0, 0, 0, 2'd0, 1, 32'h12, 32'h0, 0, 2, 32'h000000AA, 0, 1, 32'h0};
        vecs[5]  = '{1, 32'h80017FFF, 0, 2'd1, 0, 32'h12, 32'h0, 0, 2, 32'hFFFF8001, 0, 1, 32'h0};
        vecs[6]  = '{0, 0, 0, 2'd1, 0, 32'h10, 32'h0, 0, 2, 32'h00007FFF, 0, 1, 32'h0};
        vecs[7]  = '{0, 0, 0, 2'd2, 0, 32'h13, 32'h0, 1, 1, 32'h00007FFF, 0, 0, 32'h0};
        vecs[8]  = '{0, 0, 0, 2'd3, 0, 32'h10, 32'h0, 1, 1, 32'h00007FFF, 0, 0, 32'h0};
        vecs[9]  = '{0, 0, 1, 2'd1, 0, 32'h11, 32'h5555, 1, 1, 32'h00007FFF, 0, 0, 32'h0};
        vecs[10] = '{0, 0, 0, 2'd2, 0, 32'h1000, 32'h0, 1, 1, 32'h00007FFF, 0, 0, 32'h0};
        vecs[11] = '{1, 32'hCAFEF00D, 1, 2'd1, 0, 32'h16, 32'h1234BEEF, 0, 3, 32'h00007FFF, 1, 1,
                     32'hBEEFF00D};
        vecs[12] = '{0, 0, 0, 2'd1, 1, 32'h16, 32'h0, 0, 2, 32'h0000BEEF, 0, 1, 32'h0};
        vecs[13] = '{0, 0, 0, 2'd0, 0, 32'h17, 32'h0, 0, 2, 32'hFFFFFFBE, 0, 1, 32'h0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_ready", {31'b0, ready}, 32'h1);
        chk("reset_done", {31'b0, done}, 32'h0);
        chk("reset_mem_we", {31'b0, mem_we}, 32'h0);
        chk("reset_rdata", rdata, 32'h0);

        foreach (vecs[i]) begin
            if (vecs[i].pre_en) preload(int'(vecs[i].a >> 2), vecs[i].pre_val);
            model(vecs[i].w, vecs[i].sz, vecs[i].u, vecs[i].a, vecs[i].d, m_e, m_lat, m_rc, m_wc);
            run_req(vecs[i].w, vecs[i].sz, vecs[i].u, vecs[i].a, vecs[i].d,
                    lat, e, rd, wc, rc, wd, wa);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            chk($sformatf("vec%0d_err", i), {31'b0, e}, {31'b0, vecs[i].exp_err});
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_we_cycles", i), 32'(wc), 32'(vecs[i].exp_wc));
            chk($sformatf("vec%0d_re_cycles", i), 32'(rc), 32'(vecs[i].exp_rc));
            if (vecs[i].exp_wc != 0) begin
                chk($sformatf("vec%0d_mem_wd", i), wd, vecs[i].exp_wd);
                chk($sformatf("vec%0d_mem_addr", i), wa, vecs[i].a >> 2);
            end
        end

        // Reset asserted during the WR cycle of a half store must suppress the write.
        preload(6, 32'h55667788);
        @(negedge clk);
        req = 1'b1; we_req = 1'b1; size = 2'd1; unsigned_ld = 1'b0; addr = 32'h18;
        wdata = 32'h0000FFFF;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        chk("rst_seq_rd_phase", {31'b0, mem_re}, 32'h1);
        @(negedge clk);
        chk("rst_seq_wr_phase", {31'b0, mem_we}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rst_seq_we_drops", {31'b0, mem_we}, 32'h0);
        chk("rst_seq_ready", {31'b0, ready}, 32'h1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ref_rdata = '0;
        @(negedge clk);
        chk("rst_seq_mem_unchanged", mem[6], 32'h55667788);
        chk("rst_seq_ready_after", {31'b0, ready}, 32'h1);
        chk("rst_seq_rdata_cleared", rdata, 32'h0);

        for (int t = 0; t < 300; t++) begin
            sz = ($urandom_range(0, 15) == 15) ? 2'd3 : 2'($urandom_range(0, 2));
            a  = ($urandom_range(0, 15) == 0) ? 32'h1000 + $urandom_range(0, 255)
                                              : 32'($urandom_range(0, 63));
            e  = 1'($urandom);
            wd = $urandom;
            rd = {31'b0, 1'($urandom)};
            model(e, sz, rd[0], a, wd, m_e, m_lat, m_rc, m_wc);
            run_req(e, sz, rd[0], a, wd, lat, e, rd, wc, rc, wd, wa);
            chk($sformatf("rnd%0d_latency", t), 32'(lat), 32'(m_lat));
            chk($sformatf("rnd%0d_err", t), {31'b0, e}, {31'b0, m_e});
            chk($sformatf("rnd%0d_rdata", t), rd, ref_rdata);
            chk($sformatf("rnd%0d_we_cycles", t), 32'(wc), 32'(m_wc));
            chk($sformatf("rnd%0d_re_cycles", t), 32'(rc), 32'(m_rc));
        end

        for (int i = 0; i < 20; i++) begin
            chk($sformatf("final_mem_word%0d", i), mem[i], ref_mem[i]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Load/store initiator on the core side of the word-wide data memory port (wd, address, we, re, rd).
- Accepts one byte, half or word request per transaction from the multicycle datapath.
- Converts the byte address to a word index and performs a read-modify-write for sub-word stores.
- Returns aligned, sign- or zero-extended load data with a done/err handshake.

Parameters:
- DATA_WIDTH, 32, data width; the block is defined for 32 only.
- ADDR_WIDTH, 32, byte-address width and memory address-port width.
- MEM_WORDS, 1024, number of valid memory words; word index >= MEM_WORDS is an error.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  1  request; sampled only while ready=1.
- we_req  in  1  1=store, 0=load.
- size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- unsigned_ld  in  1  1=zero-extend load, 0=sign-extend.
- addr  in  ADDR_WIDTH  byte address.
- wdata  in  DATA_WIDTH  store data; the value sits in the low bits for byte/half stores.
- ready  out  1  idle, able to accept a request.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done; request rejected, no memory write.
- rdata  out  DATA_WIDTH  load result; valid with done, held until the next done.
- mem_addr  out  ADDR_WIDTH  word index = {2'b00, addr_q[ADDR_WIDTH-1:2]}.
- mem_wd  out  DATA_WIDTH  memory write data.
- mem_we  out  1  memory write enable; the write lands on the same posedge.
- mem_re  out  1  memory read enable.
- mem_rd  in  DATA_WIDTH  memory read data; combinational from mem_addr.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; ready=1.
  - done, err, mem_we, mem_re, rdata, mem_addr, mem_wd all 0.
  - Captured request registers are cleared.
  - Reset during RD or WR forces mem_we=0 immediately (combinational from state), so no write occurs at any edge after reset assertion.
- Acceptance:
  - On a posedge with state=IDLE and req=1, capture we_req, size, unsigned_ld, addr and wdata into addr_q etc.
  - Inputs are don't-care afterwards.
  - req while ready=0 is ignored; it is not queued.
- Error check (at acceptance, combinational on the inputs):
  - size=11, half with addr[0]=1, word with addr[1:0]!=0, or word index >= MEM_WORDS → err_q=1.
  - Next state is RESP directly; mem_we and mem_re are never asserted.
- FSM states: IDLE, RD, WR, RESP.
  - IDLE → RD: load, or store with size byte/half.
  - IDLE → WR: store word.
  - IDLE → RESP: error.
  - RD: mem_re=1 and mem_addr valid; mem_rd is captured into rdbuf at the posedge. Load → RESP; sub-word store → WR.
  - WR: mem_we=1; mem_wd = wdata_q for a word store, otherwise rdbuf with the selected lane replaced.
    - Byte lane = addr_q[1:0]; lane 0 = bits 7:0.
    - Half lane = addr_q[1]; half 0 = bits 15:0.
    - WR → RESP.
  - RESP: done=1 for exactly one cycle; err=err_q; ready=0. RESP → IDLE.
- Load data:
  - rdata is registered on the RD→RESP edge.
  - Selected byte/half is shifted to the low bits, then sign- or zero-extended per unsigned_ld.
  - Word loads ignore unsigned_ld.
  - On error, rdata is left unchanged.
- mem_addr and mem_wd are registered/held stable for the whole RD/WR phase. Outside RD/WR, mem_re=mem_we=0.
- Latency from the accept edge to the done cycle:
  - Load: 2 cycles (RD, RESP).
  - Word store: 2 cycles (WR, RESP).
  - Sub-word store: 3 cycles (RD, WR, RESP).
  - Error: 1 cycle.
- Back-to-back requests: ready returns in the cycle after RESP, so minimum spacing between accepts is latency+1 cycles.
- A store followed by a load to the same word returns the stored value; the write lands before the next RD.

Test Plan:
- Reset in IDLE, then release → ready=1, done=0, mem_we=0, rdata=0.
- Word store addr=0x10, wdata=0xDEADBEEF, then word load addr=0x10:
  - mem_addr=4 with mem_we=1 for one cycle.
  - done 2 cycles after the load is accepted, rdata=0xDEADBEEF.
- Preload word 4=0x11223344; byte store addr=0x12, wdata=0xAA:
  - RD then WR, mem_wd=0x11AA3344, done on the 3rd cycle.
  - Subsequent byte load addr=0x12 signed → rdata=0xFFFFFFAA; unsigned → 0x000000AA.
- Half load addr=0x12 from 0x8001_7FFF:
  - signed → 0xFFFF8001; addr=0x10 signed → 0x00007FFF.
- Misaligned word load addr=0x13, and size=11 → done next cycle with err=1, mem_re=mem_we=0, rdata unchanged.
- Assert rst_n=0 mid-WR of a half store → mem_we drops immediately, memory word unchanged, ready=1 after release.
